// File: rtl/gamma_loader_pkg.sv
// Shared definitions for the gamma LUT loader: table size, channel select codes, FSM states.
package gamma_pkg;
  localparam int GAMMA_ENTRIES = 768;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2
  } state_e;
endpackage

// File: rtl/gamma_loader_if.sv
// Download stream in, LUT write port and status out; master = host side, slave = loader.
interface gamma_loader_if;
  logic       dl_start;
  logic       dl_abort;
  logic       dl_valid;
  logic [7:0] dl_data;
  logic       dl_ready;
  logic       gamma_wr;
  logic [9:0] gamma_wr_addr;
  logic [7:0] gamma_value;
  logic       busy;
  logic       curve_valid;
  logic       err;

  modport master (
    output dl_start, dl_abort, dl_valid, dl_data,
    input  dl_ready, gamma_wr, gamma_wr_addr, gamma_value, busy, curve_valid, err
  );

  modport slave (
    input  dl_start, dl_abort, dl_valid, dl_data,
    output dl_ready, gamma_wr, gamma_wr_addr, gamma_value, busy, curve_valid, err
  );
endinterface

// File: rtl/gamma_loader.sv
// Streams a 3x256 gamma curve into the LUT write port, one registered write per accepted byte.
// Define GAMMA_INIT_EN to write an identity curve after reset before accepting downloads.
module gamma_loader
  import gamma_pkg::*;
#(
  parameter int ENTRIES = GAMMA_ENTRIES
) (
  input logic          clk_sys,
  input logic          reset,
  gamma_loader_if.slave bus
);

  localparam logic [9:0] LAST = 10'(ENTRIES - 1);
`ifdef GAMMA_INIT_EN
  localparam state_e RST_ST = ST_INIT;
`else
  localparam state_e RST_ST = ST_IDLE;
`endif

  state_e     state_q, state_d;
  logic [9:0] idx_q, idx_d;
  logic       wr_q, wr_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] val_q, val_d;
  logic       cv_q, cv_d;
  logic       err_q, err_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= RST_ST;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      val_q   <= '0;
      cv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      cv_q    <= cv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    val_d   = val_q;
    cv_d    = cv_q;
    err_d   = err_q;
    case (state_q)
`ifdef GAMMA_INIT_EN
      ST_INIT: begin
        wr_d   = 1'b1;
        addr_d = idx_q;
        val_d  = idx_q[7:0];
        idx_d  = idx_q + 10'd1;
        if (idx_q == LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cv_d    = 1'b1;
        end
      end
`endif
      ST_IDLE: begin
        if (bus.dl_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          cv_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        // abort beats restart, and both discard any byte offered alongside them
        if (bus.dl_abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cv_d    = 1'b0;
          err_d   = 1'b1;
        end else if (bus.dl_start) begin
          idx_d = '0;
          err_d = 1'b1;
        end else if (bus.dl_valid) begin
          wr_d   = 1'b1;
          addr_d = idx_q;
          val_d  = bus.dl_data;
          idx_d  = idx_q + 10'd1;
          if (idx_q == LAST) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cv_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.dl_ready      = (state_q == ST_LOAD) && !reset;
  assign bus.gamma_wr      = wr_q;
  assign bus.gamma_wr_addr = addr_q;
  assign bus.gamma_value   = val_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.curve_valid   = cv_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_gamma_loader.sv
// Scoreboarded bench: drivers push expected LUT writes, a negedge monitor pops and compares.
module tb_gamma_loader;
  import gamma_pkg::*;

  localparam int N = GAMMA_ENTRIES;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  gamma_loader_if bus();

  gamma_loader #(.ENTRIES(N)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] val;
    logic       last;
  } wr_t;

  wr_t sbq[$];
  int  vecs = 0;
  int  errs = 0;
  int  nwr = 0;
  int  max_addr = -1;
  int  m_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every LUT write outside reset must match the head of the scoreboard.
  always @(negedge clk_sys) begin
    if (!reset && bus.gamma_wr) begin
      wr_t e;
      nwr++;
      if (int'(bus.gamma_wr_addr) > max_addr) max_addr = int'(bus.gamma_wr_addr);
      if (sbq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: addr 0x%0h val 0x%0h with nothing expected",
                 bus.gamma_wr_addr, bus.gamma_value);
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", 32'(bus.gamma_wr_addr), 32'(e.addr));
        chk("wr_value", 32'(bus.gamma_value), 32'(e.val));
        chk("cv_at_write", 32'(bus.curve_valid), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_start(input logic with_byte);
    bus.dl_start = 1'b1;
    bus.dl_valid = with_byte;
    bus.dl_data  = 8'($urandom);
    tick();
    bus.dl_start = 1'b0;
    bus.dl_valid = 1'b0;
    m_idx = 0;
  endtask

  // Offer n bytes; mode 0 = 255-(k mod 256) pattern, mode 1 = random. gap enables 50% idle cycles.
  task automatic send(input int n, input int mode, input bit gap);
    int k = 0;
    while (k < n) begin
      if (gap && $urandom_range(1, 0) == 0) begin
        bus.dl_valid = 1'b0;
        bus.dl_data  = 8'($urandom);
        tick();
      end else begin
        logic [7:0] b;
        b = (mode == 0) ? 8'(255 - (m_idx % 256)) : 8'($urandom);
        bus.dl_valid = 1'b1;
        bus.dl_data  = b;
        if (bus.dl_ready !== 1'b1) begin
          vecs++;
          errs++;
          $display("FAIL dl_ready_in_load: got %b at byte %0d, expected 1", bus.dl_ready, m_idx);
        end
        sbq.push_back('{addr: 10'(m_idx), val: b, last: (m_idx == N - 1)});
        m_idx++;
        k++;
        tick();
      end
    end
    bus.dl_valid = 1'b0;
  endtask

`ifdef GAMMA_INIT_EN
  task automatic push_identity();
    for (int a = 0; a < N; a++)
      sbq.push_back('{addr: 10'(a), val: 8'(a), last: (a == N - 1)});
  endtask
`endif

  initial begin
    int n0;
    int cyc;
    bus.dl_start = 1'b0;
    bus.dl_abort = 1'b0;
    bus.dl_valid = 1'b0;
    bus.dl_data  = 8'h00;

    tick();
    tick();
    chk("rst_gamma_wr", 32'(bus.gamma_wr), 0);
    chk("rst_addr", 32'(bus.gamma_wr_addr), 0);
    chk("rst_value", 32'(bus.gamma_value), 0);
    chk("rst_dl_ready", 32'(bus.dl_ready), 0);
    chk("rst_cv", 32'(bus.curve_valid), 0);
    chk("rst_err", 32'(bus.err), 0);

`ifdef GAMMA_INIT_EN
    push_identity();
    n0 = nwr;
    reset = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 2000) begin tick(); cyc++; end
    chk("init_busy_cycles", 32'(cyc), 32'(N));
    tick();
    chk("init_writes", 32'(nwr - n0), 32'(N));
    chk("init_cv", 32'(bus.curve_valid), 1);
    chk("init_busy_done", 32'(bus.busy), 0);
    chk("init_sb_empty", 32'(sbq.size()), 0);

    // Reset in the middle of INIT: no write follows and the sequence restarts from address 0.
    reset = 1'b1;
    tick();
    tick();
    push_identity();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) tick();
    reset = 1'b1;
    sbq.delete();
    tick();
    chk("init_rst_wr_low", 32'(bus.gamma_wr), 0);
    chk("init_rst_cv", 32'(bus.curve_valid), 0);
    push_identity();
    n0 = nwr;
    reset = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 2000) begin tick(); cyc++; end
    tick();
    chk("init2_writes", 32'(nwr - n0), 32'(N));
    chk("init2_cv", 32'(bus.curve_valid), 1);
    chk("init2_sb_empty", 32'(sbq.size()), 0);
`else
    reset = 1'b0;
    tick();
    tick();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_cv", 32'(bus.curve_valid), 0);
`endif

    // Bytes and abort offered in IDLE are ignored.
    n0 = nwr;
    for (int i = 0; i < 5; i++) begin
      bus.dl_valid = 1'b1;
      bus.dl_data  = 8'($urandom);
      chk("idle_dl_ready", 32'(bus.dl_ready), 0);
      tick();
    end
    bus.dl_valid = 1'b0;
    bus.dl_abort = 1'b1;
    tick();
    bus.dl_abort = 1'b0;
    tick();
    chk("idle_abort_err", 32'(bus.err), 0);
    chk("idle_no_writes", 32'(nwr - n0), 0);

    // Full download, descending pattern, valid held high.
    pulse_start(1'b0);
    chk("dl1_busy", 32'(bus.busy), 1);
    chk("dl1_cv_cleared", 32'(bus.curve_valid), 0);
    n0 = nwr;
    send(N, 0, 1'b0);
    tick();
    tick();
    chk("dl1_writes", 32'(nwr - n0), 32'(N));
    chk("dl1_cv", 32'(bus.curve_valid), 1);
    chk("dl1_busy_done", 32'(bus.busy), 0);
    chk("dl1_err", 32'(bus.err), 0);

    // Random data with 50% valid gaps.
    pulse_start(1'b0);
    n0 = nwr;
    send(N, 1, 1'b1);
    tick();
    tick();
    chk("dl2_writes", 32'(nwr - n0), 32'(N));
    chk("dl2_cv", 32'(bus.curve_valid), 1);
    chk("dl2_sb_empty", 32'(sbq.size()), 0);

    // Abort after 300 bytes; the byte offered with the abort is dropped.
    pulse_start(1'b0);
    max_addr = -1;
    send(300, 1, 1'b1);
    bus.dl_abort = 1'b1;
    bus.dl_valid = 1'b1;
    tick();
    bus.dl_abort = 1'b0;
    bus.dl_valid = 1'b0;
    tick();
    tick();
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_cv", 32'(bus.curve_valid), 0);
    chk("abort_err", 32'(bus.err), 1);
    chk("abort_max_addr", 32'(max_addr), 299);
    chk("abort_sb_empty", 32'(sbq.size()), 0);

    // Restart after 100 bytes; next write must land at address 0.
    pulse_start(1'b0);
    chk("restart_err_cleared", 32'(bus.err), 0);
    send(100, 1, 1'b0);
    pulse_start(1'b1);
    chk("restart_err", 32'(bus.err), 1);
    chk("restart_busy", 32'(bus.busy), 1);
    send(N, 1, 1'b1);
    tick();
    tick();
    chk("restart_cv", 32'(bus.curve_valid), 1);
    chk("restart_err_sticky", 32'(bus.err), 1);

    // Start and abort together inside LOAD: abort wins.
    pulse_start(1'b0);
    send(10, 1, 1'b0);
    bus.dl_start = 1'b1;
    bus.dl_abort = 1'b1;
    tick();
    bus.dl_start = 1'b0;
    bus.dl_abort = 1'b0;
    tick();
    chk("both_busy", 32'(bus.busy), 0);
    chk("both_err", 32'(bus.err), 1);
    chk("both_cv", 32'(bus.curve_valid), 0);

    // A clean download clears err again.
    pulse_start(1'b0);
    chk("final_err_cleared", 32'(bus.err), 0);
    send(N, 1, 1'b1);
    tick();
    tick();
    chk("final_cv", 32'(bus.curve_valid), 1);
    chk("final_sb_empty", 32'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/gamma_loader.md
GAMMA_LOADER -- requirements
Module: gamma_loader

Interface
REQ-001 SHALL have parameter ENTRIES, default 768, meaning the total LUT entries (3 channels x 256).
REQ-002 SHALL have port clk_sys, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port dl_start, input, 1, a one-cycle pulse that begins a curve download.
REQ-005 SHALL have port dl_abort, input, 1, a one-cycle pulse that cancels a download in progress.
REQ-006 SHALL have port dl_valid, input, 1, meaning a curve byte is present on dl_data.
REQ-007 SHALL have port dl_data, input, 8, the curve byte, in order R[0..255], G[0..255], B[0..255].
REQ-008 SHALL have port dl_ready, output, 1, meaning the loader accepts dl_data in this cycle.
REQ-009 SHALL have port gamma_wr, output, 1, the LUT write strobe.
REQ-010 SHALL have port gamma_wr_addr, output, 10, the LUT write address; bits [9:8] select the channel (0=R, 1=G, 2=B).
REQ-011 SHALL have port gamma_value, output, 8, the LUT write data.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port curve_valid, output, 1, high when the LUT holds a complete curve.
REQ-014 SHALL have port err, output, 1, a sticky flag set by an aborted or interrupted download.

Function
REQ-015 SHALL implement states INIT, IDLE and LOAD.
REQ-016 SHALL count a byte as accepted when dl_valid and dl_ready are both high in the same cycle.
REQ-017 SHALL drive dl_ready high only in LOAD; bytes offered in other states are ignored.
REQ-018 SHALL, in LOAD, use an internal index idx starting at 0 and write each accepted byte with gamma_wr=1, gamma_wr_addr=idx and gamma_value=dl_data on the following cycle (latency 1).
REQ-019 SHALL increment idx by one per accepted byte, and never skip or repeat an index.
REQ-020 SHALL, when the byte at idx=ENTRIES-1 is accepted, go to IDLE and set curve_valid=1 in the same cycle as that final write.
REQ-021 SHALL, on dl_start in IDLE, go to LOAD, set idx=0, clear curve_valid and clear err.
REQ-022 SHALL, on dl_start during LOAD, restart with idx=0 and set err=1; a byte accepted in that same cycle is discarded.
REQ-023 SHALL, on dl_abort during LOAD, go to IDLE with curve_valid=0 and err=1; a byte accepted in that same cycle is discarded.
REQ-024 SHALL ignore dl_abort outside LOAD.
REQ-025 SHALL let dl_abort take priority when dl_start and dl_abort arrive together.
REQ-026 SHALL ignore dl_start during INIT.
REQ-027 SHALL hold gamma_wr low whenever no write is due, and keep gamma_wr_addr and gamma_value stable at their last values.
REQ-028 SHALL never produce gamma_wr_addr greater than or equal to ENTRIES.

Reset
REQ-029 SHALL, while reset is high, set gamma_wr=0, gamma_wr_addr=0, gamma_value=0, dl_ready=0, curve_valid=0, err=0 and idx=0.
REQ-030 SHALL leave reset in state INIT when GAMMA_INIT_EN is defined, and in IDLE otherwise.
REQ-031 SHALL abandon any INIT or LOAD sequence in progress when reset is asserted; no further writes follow.

Configuration
REQ-032 SHALL recognise the macro GAMMA_INIT_EN.
REQ-033 SHALL, with GAMMA_INIT_EN defined, in INIT write an identity curve: one write per cycle, addr 0..ENTRIES-1, value=addr[7:0]; then go to IDLE with curve_valid=1; busy is high for ENTRIES cycles.
REQ-034 SHALL, without GAMMA_INIT_EN, contain no INIT logic; curve_valid stays 0 until the first complete download.

Structure
REQ-035 SHALL place the ENTRIES default (GAMMA_ENTRIES=768), the channel-select encodings and the state enum in the shared package gamma_pkg.
REQ-036 SHALL be a single module; no sub-module is warranted.

Verification
REQ-037 SHALL cover: GAMMA_INIT_EN defined, reset released -> 768 writes over 768 cycles, addr 0x000 gets 0x00, 0x1FF gets 0xFF, 0x2FF gets 0xFF; then curve_valid=1 and busy=0.
REQ-038 SHALL cover: dl_start, then 768 bytes with byte k = 255-(k mod 256) and dl_valid held high -> writes 0x000=0xFF and 0x2FF=0x00; curve_valid=1 in the cycle of the last write.
REQ-039 SHALL cover: random dl_valid gaps (50% duty) -> exactly 768 writes with no duplicate or skipped address.
REQ-040 SHALL cover: dl_abort after 300 bytes -> state IDLE, curve_valid=0, err=1, no write above addr 299.
REQ-041 SHALL cover: dl_start after 100 bytes -> err=1 and the next write goes to addr 0x000.
REQ-042 SHALL cover: reset asserted at INIT cycle 400 -> gamma_wr=0 the next cycle and INIT restarts from addr 0.
